hilo_mdu_sequencer: RTL and testbench

//  Iterative multiply/divide sequencer that owns the architectural HI/LO registers for the pipelined datapath.

---
 rtl/hilo_mdu_sequencer.sv | 155 +++++++++++++++
 tb/tb_hilo_mdu_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign fix-up in a final cycle.
module hilo_mdu_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_flush,
   input  logic             i_hilo_read,
   input  logic             i_wr_hi,
   input  logic             i_wr_lo,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_zero,
   output logic             o_stall
);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   localparam logic [CNT_W-1:0] LP_CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(1);

   state_e               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_p;
   logic [WIDTH-1:0]     r_opnd;
   logic                 r_is_div, r_neg_res, r_neg_rem, r_b_zero;
   logic [WIDTH-1:0]     r_hi, r_lo;
   logic                 r_done, r_div_zero;

   logic                 w_start_ok;
   logic                 w_a_neg, w_b_neg;
   logic [WIDTH-1:0]     w_a_mag, w_b_mag;
   logic [WIDTH:0]       w_add;
   logic [2*WIDTH-1:0]   w_mul_p, w_div_p, w_prod;
   logic [WIDTH:0]       w_rem_sh;
   logic [WIDTH-1:0]     w_diff;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_quot, w_rem, w_fix_hi, w_fix_lo;

   assign w_start_ok = i_start & ~i_flush;

   // i_op[0] selects signed, i_op[1] selects divide
   assign w_a_neg = i_op[0] & i_a[WIDTH-1];
   assign w_b_neg = i_op[0] & i_b[WIDTH-1];
   assign w_a_mag = w_a_neg ? -i_a : i_a;
   assign w_b_mag = w_b_neg ? -i_b : i_b;

   // Multiply step: conditional add into the high half, then shift the pair right
   assign w_add   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : '0);
   assign w_mul_p = {w_add, r_p[WIDTH-1:1]};

   // Restoring divide step: remainder:quotient pair shifted left, trial subtract
   assign w_rem_sh = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
   assign w_ge     = w_rem_sh >= {1'b0, r_opnd};
   assign w_diff   = w_rem_sh[WIDTH-1:0] - r_opnd;
   assign w_div_p  = {(w_ge ? w_diff : w_rem_sh[WIDTH-1:0]), r_p[WIDTH-2:0], w_ge};

   assign w_prod   = r_neg_res ? -r_p : r_p;
   assign w_quot   = r_neg_res ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
   assign w_rem    = r_neg_rem ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
   assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
   assign w_fix_lo = r_is_div ? (r_b_zero ? '1 : w_quot) : w_prod[WIDTH-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle: if (w_start_ok) w_state_nxt = StRun;
         StRun: begin
            if (i_flush) begin
               w_state_nxt = StIdle;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_state_nxt = StFix;
            end
         end
         StFix:   w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_p        <= '0;
         r_opnd     <= '0;
         r_is_div   <= 1'b0;
         r_neg_res  <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_b_zero   <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_start_ok) begin
                  r_cnt     <= LP_CNT_INIT;
                  r_is_div  <= i_op[1];
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_rem <= w_a_neg;
                  r_b_zero  <= i_op[1] & (i_b == '0);
                  // Multiply adds |A| and shifts |B| out; divide shifts |A| in and subtracts |B|
                  r_opnd    <= i_op[1] ? w_b_mag : w_a_mag;
                  r_p       <= {{WIDTH{1'b0}}, (i_op[1] ? w_a_mag : w_b_mag)};
               end else begin
                  if (i_wr_hi) r_hi <= i_wr_data;
                  if (i_wr_lo) r_lo <= i_wr_data;
               end
            end
            StRun: begin
               if (!i_flush) begin
                  r_cnt <= r_cnt - LP_CNT_LAST;
                  r_p   <= r_is_div ? w_div_p : w_mul_p;
               end
            end
            StFix: begin
               if (!i_flush) begin
                  r_hi       <= w_fix_hi;
                  r_lo       <= w_fix_lo;
                  r_done     <= 1'b1;
                  r_div_zero <= r_b_zero;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_hi       = r_hi;
   assign o_lo       = r_lo;
   assign o_busy     = (r_state != StIdle);
   assign o_done     = r_done;
   assign o_div_zero = r_div_zero;
   assign o_stall    = o_busy & (i_start | i_hilo_read | i_wr_hi | i_wr_lo);

endmodule

// File: tb/tb_hilo_mdu_sequencer.sv
// Randomized plus directed bench for hilo_mdu_sequencer against an arithmetic reference model.
module tb_hilo_mdu_sequencer;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0, flush = 1'b0, hilo_read = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] a = '0, b = '0, wr_data = '0;
   wire  [W-1:0] hi, lo;
   wire          busy, done, div_zero, stall;

   int           n_vec = 0;
   int           n_err = 0;
   logic [W-1:0] m_hi = '0, m_lo = '0;

   hilo_mdu_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
      .i_flush(flush), .i_hilo_read(hilo_read), .i_wr_hi(wr_hi), .i_wr_lo(wr_lo),
      .i_wr_data(wr_data), .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done),
      .o_div_zero(div_zero), .o_stall(stall)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain 64-bit and 32-bit arithmetic, MIPS corner cases handled explicitly
   function automatic void ref_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output logic edz);
      longint sx, sy, sp;
      logic [63:0] p;
      int ix, iy;
      edz = 1'b0;
      case (o)
         2'd0: begin
            p  = {32'b0, x} * {32'b0, y};
            eh = p[63:32];
            el = p[31:0];
         end
         2'd1: begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            sp = sx * sy;
            p  = sp;
            eh = p[63:32];
            el = p[31:0];
         end
         default: begin
            if (y == 0) begin
               eh  = x;
               el  = '1;
               edz = 1'b1;
            end else if (o == 2'd2) begin
               el = x / y;
               eh = x % y;
            end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
               el = 32'h8000_0000;
               eh = '0;
            end else begin
               ix = int'(x);
               iy = int'(y);
               el = ix / iy;
               eh = ix % iy;
            end
         end
      endcase
   endfunction

   task automatic wait_done(output int lat, output int busy_cyc, output bit held);
      lat = 0;
      busy_cyc = 0;
      held = 1'b1;
      while (!done && lat < 100) begin
         if (busy) busy_cyc++;
         if (hi !== m_hi || lo !== m_lo) held = 1'b0;
         step();
         lat++;
      end
      if (lat >= 100) check("done_timeout", 64'(lat), 64'(W + 1));
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input string tag, input bit chk_lat);
      logic [W-1:0] eh, el;
      logic edz;
      int lat, bc;
      bit held;
      ref_op(o, x, y, eh, el, edz);
      op = o;
      a = x;
      b = y;
      start = 1'b1;
      #1;
      check({tag, "_idle_stall"}, 64'(stall), 64'd0);
      step();
      start = 1'b0;
      wait_done(lat, bc, held);
      if (chk_lat) begin
         check({tag, "_lat"}, 64'(lat), 64'(W + 1));
         check({tag, "_busy_cyc"}, 64'(bc), 64'(W + 1));
      end
      check({tag, "_held"}, 64'(held), 64'd1);
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      check({tag, "_dz"}, 64'(div_zero), 64'(edz));
      check({tag, "_busy_off"}, 64'(busy), 64'd0);
      m_hi = eh;
      m_lo = el;
      step();
      check({tag, "_done_pulse"}, 64'({done, div_zero}), 64'd0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 6))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int lat, bc;
      bit held, saw_done;
      logic [W-1:0] eh, el;
      logic edz;

      #3;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_flags", 64'({busy, done, div_zero, stall}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      run_op(2'd1, 32'hFFFF_FFFD, 32'd7, "t1_mult", 1'b1);
      run_op(2'd2, 32'd100, 32'd7, "t2_divu", 1'b1);
      run_op(2'd3, 32'hFFFF_FFF9, 32'd2, "t2_div", 1'b1);
      run_op(2'd2, 32'd5, 32'd0, "t3_divu0", 1'b1);
      run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t3_multu", 1'b1);
      run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, "ovf_div", 1'b1);
      run_op(2'd3, 32'hFFFF_FF00, 32'd0, "div0_neg", 1'b0);

      // MTHI/MTLO in IDLE, both at once; no Done
      wr_hi = 1'b1;
      wr_lo = 1'b1;
      wr_data = 32'hCAFE_F00D;
      step();
      wr_hi = 1'b0;
      wr_lo = 1'b0;
      m_hi = 32'hCAFE_F00D;
      m_lo = 32'hCAFE_F00D;
      check("mt_both_hi", 64'(hi), 64'(m_hi));
      check("mt_both_lo", 64'(lo), 64'(m_lo));
      check("mt_no_done", 64'({done, div_zero}), 64'd0);

      // Hazards while busy: read, new start, MTHI all stall and are ignored
      ref_op(2'd3, 32'd1000, 32'hFFFF_FFFD, eh, el, edz);
      op = 2'd3; a = 32'd1000; b = 32'hFFFF_FFFD; start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      hilo_read = 1'b1;
      #1;
      check("t4_stall_read", 64'(stall), 64'd1);
      check("t4_hi_old", 64'(hi), 64'(m_hi));
      step();
      hilo_read = 1'b0;
      start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5;
      #1;
      check("t4_stall_start", 64'(stall), 64'd1);
      step();
      start = 1'b0;
      wr_hi = 1'b1;
      wr_data = 32'hDEAD_BEEF;
      #1;
      check("t4_stall_wrhi", 64'(stall), 64'd1);
      step();
      wr_hi = 1'b0;
      check("t4_wrhi_ignored", 64'(hi), 64'(m_hi));
      wait_done(lat, bc, held);
      check("t4_held", 64'(held), 64'd1);
      check("t4_hi", 64'(hi), 64'(eh));
      check("t4_lo", 64'(lo), 64'(el));
      m_hi = eh;
      m_lo = el;
      step();
      check("t4_no_restart", 64'(busy), 64'd0);
      hilo_read = 1'b1;
      #1;
      check("t4_idle_read_nostall", 64'(stall), 64'd0);
      hilo_read = 1'b0;

      // Flush at RUN cycle 10
      op = 2'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t5_flush_busy", 64'(busy), 64'd0);
      saw_done = 1'b0;
      for (int i = 0; i < W + 4; i++) begin
         if (done || div_zero || busy) saw_done = 1'b1;
         step();
      end
      check("t5_flush_no_done", 64'(saw_done), 64'd0);
      check("t5_flush_hi", 64'(hi), 64'(m_hi));
      check("t5_flush_lo", 64'(lo), 64'(m_lo));

      // Start + MTLO same IDLE cycle: op wins, write dropped
      ref_op(2'd0, 32'd6, 32'd7, eh, el, edz);
      op = 2'd0; a = 32'd6; b = 32'd7; start = 1'b1; wr_lo = 1'b1; wr_data = 32'h0000_AAAA;
      step();
      start = 1'b0;
      wr_lo = 1'b0;
      check("t5_start_busy", 64'(busy), 64'd1);
      check("t5_wrlo_dropped", 64'(lo), 64'(m_lo));
      wait_done(lat, bc, held);
      check("t5_res", 64'({hi, lo}), {eh, el});
      m_hi = eh;
      m_lo = el;
      step();

      // Flush with Start in IDLE drops the op but not the MTHI
      start = 1'b1; flush = 1'b1; wr_hi = 1'b1; wr_data = 32'h0000_BEEF;
      step();
      start = 1'b0; flush = 1'b0; wr_hi = 1'b0;
      m_hi = 32'h0000_BEEF;
      check("flush_idle_busy", 64'(busy), 64'd0);
      check("flush_idle_wrhi", 64'(hi), 64'(m_hi));

      // Random ops interleaved with random MTHI/MTLO
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            wr_hi = 1'($urandom);
            wr_lo = 1'($urandom);
            wr_data = W'($urandom);
            step();
            if (wr_hi) m_hi = wr_data;
            if (wr_lo) m_lo = wr_data;
            wr_hi = 1'b0;
            wr_lo = 1'b0;
            check("rnd_mt", 64'({hi, lo}), {m_hi, m_lo});
         end
         run_op(2'($urandom_range(0, 3)), pick(), pick(), "rnd", 1'b1);
      end

      // Async reset mid-RUN
      op = 2'd1; a = 32'h1234_5678; b = 32'h8765_4321; start = 1'b1;
      step();
      start = 1'b0;
      repeat (14) step();
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_hi", 64'(hi), 64'd0);
      check("t6_rst_lo", 64'(lo), 64'd0);
      check("t6_rst_flags", 64'({busy, done, div_zero}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      wr_hi = 1'b1;
      wr_data = 32'h0000_1234;
      step();
      wr_hi = 1'b0;
      check("t6_wrhi", 64'(hi), 64'h0000_1234);
      check("t6_lo_zero", 64'(lo), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
